// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud-tick parameters
// and a counter-width helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int DEFAULT_TICK_DIV   = 163;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Transmitter request/serial interface. Handshake: a request is taken on any
// rising edge where tx_start=1 and tx_ready=1; tx_start is ignored otherwise.
interface uart_tx_if import uart_pkg::*; #(parameter int DATA_BITS = 8);

  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done_tick;
  logic                 tx;
  state_t               state;

  modport master (
    output tx_start, tx_data,
    input  tx_ready, tx_done_tick, tx, state
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_ready, tx_done_tick, tx, state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..TICK_DIV-1 and pulses tick for one clock
// on the wrap cycle. clear restarts the count so a new frame starts phase-aligned.
module uart_baud_tick import uart_pkg::*; #(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == DIV_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first frames of start, DATA_BITS payload, optional even
// parity (macro UART_TX_PARITY_EN) and STOP_BITS stop bits on a registered tx line.
module uart_tx import uart_pkg::*; #(
  parameter int TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic     clock,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int OS_W  = cnt_width(OVERSAMPLE);
  localparam int BIT_W = cnt_width(DATA_BITS);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [0:0]       STOP_LAST = 1'(STOP_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [0:0]           stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 tick, clear, done, bit_end, accept;

  uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  assign accept  = (state_q == IDLE) && bus.tx_start;
  assign bit_end = tick && (os_q == OS_LAST);

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  // Even parity of the captured payload, held for the whole frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.tx_data;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    os_d    = os_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    clear   = 1'b0;
    done    = 1'b0;

    if (state_q != IDLE && tick) begin
      os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          os_d    = '0;
          bit_d   = '0;
          stop_d  = '0;
          clear   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the next state so the line changes on the same
  // edge as the state and carries no decode glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.tx_ready     = (state_q == IDLE);
  assign bus.tx_done_tick = done;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with TICK_DIV=4, OVERSAMPLE=16 (64 clocks per bit);
// honours UART_TX_PARITY_EN for the expected frame layout.
module tb_uart_tx;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   cyc;
  int   done_a, done_b, done_c;

  uart_tx_if #(.DATA_BITS(8)) bus ();

  uart_tx #(
    .TICK_DIV   (4),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .STOP_BITS  (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock/reset
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Called just after the acceptance edge; checks every clock of the frame and
  // returns at the first clock after the done pulse. inject_at>0 pulses a
  // request for 8'hFF at that clock, which must be ignored.
  task automatic run_frame(input logic [7:0] d, input int inject_at, output int done_cyc);
    done_cyc = -1;
    for (int c = 1; c <= FRAME_CLKS; c++) begin
      check("tx_bit", 32'(bus.tx), 32'(exp_bit(d, (c - 1) / BIT_CLKS)));
      check("ready_busy", 32'(bus.tx_ready), 32'd0);
      check("done_tick", 32'(bus.tx_done_tick), 32'(c == FRAME_CLKS));
      if (bus.tx_done_tick && done_cyc < 0) done_cyc = cyc;
      if (c == inject_at) begin
        bus.tx_start = 1'b1;
        bus.tx_data  = 8'hFF;
      end else if (inject_at > 0 && c == inject_at + 1) begin
        bus.tx_start = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    reset  = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;

    // 1. reset and long idle
    repeat (3) step();
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_done", 32'(bus.tx_done_tick), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      check("idle_tx", 32'(bus.tx), 32'd1);
      check("idle_ready", 32'(bus.tx_ready), 32'd1);
      check("idle_done", 32'(bus.tx_done_tick), 32'd0);
    end

    // 2. single frame 8'hA5
    bus.tx_data  = 8'hA5;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    check("a5_state_start", 32'(bus.state), 32'(START));
    run_frame(8'hA5, 0, done_a);
    check("a5_end_tx", 32'(bus.tx), 32'd1);
    check("a5_end_ready", 32'(bus.tx_ready), 32'd1);
    check("a5_end_state", 32'(bus.state), 32'(IDLE));
    step();

    // 3. request for 8'hFF mid-frame is dropped
    bus.tx_data  = 8'h3C;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    run_frame(8'h3C, 200, done_a);
    check("3c_after_ready", 32'(bus.tx_ready), 32'd1);
    check("3c_after_tx", 32'(bus.tx), 32'd1);
    step();
    check("3c_no_queue_state", 32'(bus.state), 32'(IDLE));
    check("3c_no_queue_tx", 32'(bus.tx), 32'd1);

    // 4. back-to-back with tx_start held high
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b1;
    step();
    run_frame(8'h00, 0, done_b);
    check("b2b_gap_tx", 32'(bus.tx), 32'd1);
    check("b2b_gap_ready", 32'(bus.tx_ready), 32'd1);
    check("b2b_gap_done", 32'(bus.tx_done_tick), 32'd0);
    bus.tx_data = 8'h81;
    step();
    bus.tx_start = 1'b0;
    check("b2b_second_low", 32'(bus.tx), 32'd0);
    run_frame(8'h81, 0, done_c);
    check("b2b_done_spacing", 32'(done_c - done_b), 32'd641);

    // 5. reset at clock 300 of frame 8'h55
    bus.tx_data  = 8'h55;
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    repeat (298) step();
    check("55_mid_bit3", 32'(bus.tx), 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tx", 32'(bus.tx), 32'd1);
    check("abort_ready", 32'(bus.tx_ready), 32'd1);
    check("abort_state", 32'(bus.state), 32'(IDLE));
    step();
    check("abort_idle_tx", 32'(bus.tx), 32'd1);
    bus.tx_start = 1'b1;
    step();
    bus.tx_start = 1'b0;
    run_frame(8'h55, 0, done_a);

    // 6. frame length (parity-dependent)
    bus.tx_data  = 8'h07;
    bus.tx_start = 1'b1;
    step();
    done_b = cyc;
    bus.tx_start = 1'b0;
    run_frame(8'h07, 0, done_a);
    check("07_frame_len", 32'(done_a - done_b + 1), 32'(FRAME_CLKS));
    check("07_end_tx", 32'(bus.tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
